wr_sl_return_n: RTL

Parametrised write-channel return path for one master port of the AXI interconnect, scaling to NUM_SLAVES slaves. It routes slave AWREADY/WREADY/BVALID/BRESP back to the master and routes master BREADY to the owning slave. An ordering queue tracks up to MAX_OUTST outstanding writes, so W data and B responses follow AW order. Unmapped selects go to an internal default slave that answers DECERR.

---
 rtl/wr_ret_pkg.sv | 17 +
 rtl/wr_ord_fifo.sv | 53 +++++
 rtl/wr_sl_return_n.sv | 128 ++++++++++++
 3 files changed

// File: rtl/wr_ret_pkg.sv
// Shared constants and helpers for the write-channel return path.
package wr_ret_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  // Ceiling log2, used to size queue pointers.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/wr_ord_fifo.sv
// Three-pointer ordering queue: entries are pushed at AW, released for W in
// order (aw_w), and popped at B (rp). occ counts all entries, wpend counts
// entries whose W burst has not finished yet.
module wr_ord_fifo
  import wr_ret_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ID_W  = 3,
  localparam int PW   = clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [ID_W-1:0] push_id,
  input  logic            w_adv,
  input  logic            pop,
  output logic [ID_W-1:0] head,
  output logic [ID_W-1:0] w_owner,
  output logic [PW:0]     occ,
  output logic [PW:0]     wpend
);

  localparam logic [PW-1:0] PTR_ONE = 1;

  logic [PW-1:0]   wp, aw_w, rp;
  logic [ID_W-1:0] mem [DEPTH];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      aw_w  <= '0;
      rp    <= '0;
      occ   <= '0;
      wpend <= '0;
    end else begin
      if (push)  wp   <= wp + PTR_ONE;
      if (w_adv) aw_w <= aw_w + PTR_ONE;
      if (pop)   rp   <= rp + PTR_ONE;
      occ   <= occ   + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      wpend <= wpend + {{PW{1'b0}}, push} - {{PW{1'b0}}, w_adv};
    end
  end

  // Entry storage; contents beyond occ are don't-care, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= push_id;
  end

  assign head    = mem[rp];
  assign w_owner = mem[aw_w];

endmodule

// File: rtl/wr_sl_return_n.sv
// Write-channel return path for one master port. Routes slave AW/W ready and
// B response back to the master in AW order; unmapped selects are answered by
// an internal default slave with DECERR.
// Optional: define WR_RESP_ERR_CNT_EN to add a saturating error-response
// counter output err_cnt.
module wr_sl_return_n
  import wr_ret_pkg::*;
#(
  parameter int NUM_SLAVES = 2,
  parameter int SEL_W      = 3,
  parameter int MAX_OUTST  = 4
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    m_AWVALID,
  input  logic [SEL_W-1:0]        slv_sel,
  input  logic                    m_WVALID,
  input  logic                    m_WLAST,
  input  logic                    m_BREADY,
  input  logic [NUM_SLAVES-1:0]   s_AWREADY,
  input  logic [NUM_SLAVES-1:0]   s_WREADY,
  input  logic [NUM_SLAVES-1:0]   s_BVALID,
  input  logic [2*NUM_SLAVES-1:0] s_BRESP,
  output logic [NUM_SLAVES-1:0]   s_BREADY,
  output logic [SEL_W-1:0]        s_WSEL,
  output logic                    wr_AWREADY,
  output logic                    wr_WREADY,
  output logic                    wr_BVALID,
`ifdef WR_RESP_ERR_CNT_EN
  output logic [15:0]             err_cnt,
`endif
  output logic [1:0]              wr_BRESP
);

  localparam int PW = clog2(MAX_OUTST);
  localparam logic [PW:0] OCC_MAX = (PW+1)'(MAX_OUTST);

  logic [SEL_W-1:0]      head, w_owner;
  logic [PW:0]           occ, wpend;
  logic                  push, w_adv, pop;
  logic                  aw_hit, own_hit, head_hit;
  logic                  aw_slv_rdy, w_slv_rdy, b_slv_valid;
  logic [1:0]            b_slv_resp;
  logic [NUM_SLAVES-1:0] head_onehot;

  wr_ord_fifo #(
    .DEPTH (MAX_OUTST),
    .ID_W  (SEL_W)
  ) u_fifo (
    .clk     (ACLK),
    .rst     (ARESET),
    .push    (push),
    .push_id (slv_sel),
    .w_adv   (w_adv),
    .pop     (pop),
    .head    (head),
    .w_owner (w_owner),
    .occ     (occ),
    .wpend   (wpend)
  );

  // Pick the addressed slave for AW, the W owner and the B head; a miss
  // means the id is unmapped and the default slave answers.
  always_comb begin
    aw_hit      = 1'b0;
    own_hit     = 1'b0;
    head_hit    = 1'b0;
    aw_slv_rdy  = 1'b0;
    w_slv_rdy   = 1'b0;
    b_slv_valid = 1'b0;
    b_slv_resp  = OKAY;
    head_onehot = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (slv_sel == SEL_W'(i)) begin
        aw_hit     = 1'b1;
        aw_slv_rdy = s_AWREADY[i];
      end
      if (w_owner == SEL_W'(i)) begin
        own_hit   = 1'b1;
        w_slv_rdy = s_WREADY[i];
      end
      if (head == SEL_W'(i)) begin
        head_hit       = 1'b1;
        b_slv_valid    = s_BVALID[i];
        b_slv_resp     = s_BRESP[2*i +: 2];
        head_onehot[i] = 1'b1;
      end
    end
  end

  // Return-path outputs, forced low while reset is held.
  always_comb begin
    wr_AWREADY = 1'b0;
    wr_WREADY  = 1'b0;
    wr_BVALID  = 1'b0;
    wr_BRESP   = OKAY;
    s_BREADY   = '0;
    s_WSEL     = '0;
    if (!ARESET) begin
      wr_AWREADY = (occ < OCC_MAX) & (aw_hit ? aw_slv_rdy : 1'b1);
      if (wpend != '0) begin
        wr_WREADY = own_hit ? w_slv_rdy : 1'b1;
        s_WSEL    = w_owner;
      end
      if (occ > wpend) begin
        wr_BVALID = head_hit ? b_slv_valid : 1'b1;
        wr_BRESP  = head_hit ? b_slv_resp : DECERR;
        s_BREADY  = head_onehot & {NUM_SLAVES{m_BREADY}};
      end
    end
  end

  assign push  = m_AWVALID & wr_AWREADY;
  assign w_adv = m_WVALID & wr_WREADY & m_WLAST;
  assign pop   = wr_BVALID & m_BREADY;

`ifdef WR_RESP_ERR_CNT_EN
  // Saturating count of completed B responses other than OKAY.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      err_cnt <= '0;
    end else if (pop && (wr_BRESP != OKAY) && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule
